// File: rtl/aes128_iter_core_pkg.sv
// -----------------------------------------------------------------------------
// aes128_iter_core_pkg
// Shared definitions for the iterative AES-128 core: round count, block width,
// FSM state enum, the legal UNROLL set with its elaboration check, and the
// AES round primitives (subBytes, shiftRows, mixColumns, addRoundKey,
// keyExpansion) used by aes_round.
// Byte order everywhere: byte 0 = bits [127:120]; the state is column-major,
// so byte index b sits in row b%4, column b/4.
// -----------------------------------------------------------------------------
package aes128_iter_core_pkg;

  localparam int NR      = 10;
  localparam int BLOCK_W = 128;

  typedef logic [BLOCK_W-1:0] block_t;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  // Bit n set means UNROLL=n is legal: 1, 2, 5, 10 (the divisors of NR).
  localparam logic [NR:0] LEGAL_UNROLL_MASK = 11'b100_0010_0110;

  function automatic bit unroll_is_legal(input int unroll);
    if (unroll < 1 || unroll > NR) return 1'b0;
    return LEGAL_UNROLL_MASK[unroll];
  endfunction

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic block_t sub_bytes(input block_t s);
    block_t r;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = SBOX[s[8*i +: 8]];
    return r;
  endfunction

  // Row r rotates left by r columns.
  function automatic block_t shift_rows(input block_t s);
    block_t r;
    for (int c = 0; c < 4; c++) begin
      for (int row = 0; row < 4; row++) begin
        r[127-8*(4*c+row) -: 8] = s[127-8*(4*((c+row)%4)+row) -: 8];
      end
    end
    return r;
  endfunction

  function automatic block_t mix_columns(input block_t s);
    block_t      r;
    logic [7:0]  a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      r[127-32*c -: 32] = {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                           a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                           a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                           xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    end
    return r;
  endfunction

  function automatic block_t add_round_key(input block_t s, input block_t k);
    return s ^ k;
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] round);
    case (round)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  // One step of the key schedule: previous round key -> next round key.
  function automatic block_t key_expansion(input block_t k, input logic [7:0] rc);
    logic [31:0] rot, t, n0, n1, n2, n3;
    rot = {k[23:0], k[31:24]};
    t   = {SBOX[rot[31:24]], SBOX[rot[23:16]], SBOX[rot[15:8]], SBOX[rot[7:0]]} ^ {rc, 24'h0};
    n0  = k[127:96] ^ t;
    n1  = k[95:64]  ^ n0;
    n2  = k[63:32]  ^ n1;
    n3  = k[31:0]   ^ n2;
    return {n0, n1, n2, n3};
  endfunction

endpackage

// File: rtl/aes128_iter_core_if.sv
// -----------------------------------------------------------------------------
// aes128_iter_core_if
// Block-in / ciphertext-out handshake bundle of the iterative AES-128 core.
//   in_valid/in_ready   : plaintext+key transfer (valid/ready)
//   plaintext, key      : 128-bit input block and cipher key
//   out_valid/out_ready : ciphertext transfer (valid/ready)
//   ciphertext          : 128-bit result, stable while out_valid is high
//   busy                : core is in RUN or DONE
// master = block source/ciphertext sink side, slave = the core.
// -----------------------------------------------------------------------------
interface aes128_iter_core_if;
  import aes128_iter_core_pkg::*;

  logic   in_valid;
  logic   in_ready;
  block_t plaintext;
  block_t key;
  logic   out_valid;
  logic   out_ready;
  block_t ciphertext;
  logic   busy;

  modport master (
    output in_valid, plaintext, key, out_ready,
    input  in_ready, out_valid, ciphertext, busy
  );

  modport slave (
    input  in_valid, plaintext, key, out_ready,
    output in_ready, out_valid, ciphertext, busy
  );
endinterface

// File: rtl/aes128_iter_core_round.sv
// -----------------------------------------------------------------------------
// aes_round
// One combinational AES-128 round with on-the-fly key expansion.
//   state_in  : state entering the round
//   key_in    : previous round key (the cipher key for round 1)
//   round_i   : round number 1..10, selects rcon
//   is_last   : final round, mixColumns is bypassed
//   state_out : state after addRoundKey
//   key_out   : round key used by this round, feeds the next stage
// -----------------------------------------------------------------------------
module aes_round
  import aes128_iter_core_pkg::*;
(
  input  block_t     state_in,
  input  block_t     key_in,
  input  logic [3:0] round_i,
  input  logic       is_last,
  output block_t     state_out,
  output block_t     key_out
);

  block_t shifted;
  block_t mixed;

  assign key_out   = key_expansion(key_in, rcon(round_i));
  assign shifted   = shift_rows(sub_bytes(state_in));
  assign mixed     = is_last ? shifted : mix_columns(shifted);
  assign state_out = add_round_key(mixed, key_out);

endmodule

// File: rtl/aes128_iter_core.sv
// -----------------------------------------------------------------------------
// aes128_iter_core
// Iterative AES-128 encryption core: UNROLL rounds per clock, key schedule
// computed alongside the data path, valid/ready on both sides.
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset
//   bus   : aes128_iter_core_if.slave (in_valid/in_ready/plaintext/key,
//           out_valid/out_ready/ciphertext, busy)
// Parameter UNROLL: rounds per clock, one of 1, 2, 5, 10.
// Latency accept -> out_valid is NR/UNROLL edges; with out_ready held high a
// new block is accepted every NR/UNROLL+2 cycles.
// -----------------------------------------------------------------------------
module aes128_iter_core
  import aes128_iter_core_pkg::*;
#(
  parameter int UNROLL = 1
) (
  input logic              clk,
  input logic              rst_n,
  aes128_iter_core_if.slave bus
);

  if (!unroll_is_legal(UNROLL)) begin : g_bad_unroll
    $error("aes128_iter_core: UNROLL=%0d is not one of 1, 2, 5, 10", UNROLL);
  end

  state_e     state_q;
  block_t     st_q;
  block_t     rk_q;
  block_t     ct_q;
  logic [3:0] rnd_q;
  logic       in_ready_q;
  logic       out_valid_q;
  logic       busy_q;

  // Each stage owns its nets so the chain reads as distinct signals rather
  // than one array feeding back on itself.
  for (genvar i = 0; i < UNROLL; i++) begin : g_round
    block_t     st_in, rk_in, st_out, rk_out;
    logic [3:0] round_num;

    if (i == 0) begin : g_first
      assign st_in = st_q;
      assign rk_in = rk_q;
    end else begin : g_next
      assign st_in = g_round[i-1].st_out;
      assign rk_in = g_round[i-1].rk_out;
    end

    assign round_num = rnd_q + 4'(i);

    aes_round u_round (
      .state_in  (st_in),
      .key_in    (rk_in),
      .round_i   (round_num),
      .is_last   (round_num == 4'(NR)),
      .state_out (st_out),
      .key_out   (rk_out)
    );
  end

  block_t stage_st;
  block_t stage_rk;
  logic   final_pass;

  assign stage_st   = g_round[UNROLL-1].st_out;
  assign stage_rk   = g_round[UNROLL-1].rk_out;
  // UNROLL divides NR and rnd starts at 1, so only the last stage of the
  // last pass ever reaches round NR.
  assign final_pass = (g_round[UNROLL-1].round_num == 4'(NR));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: the data registers are cleared as well, so an aborted block
      // can never surface later as a stale ciphertext.
      state_q     <= IDLE;
      st_q        <= '0;
      rk_q        <= '0;
      ct_q        <= '0;
      rnd_q       <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          in_ready_q <= 1'b1;
          if (bus.in_valid && in_ready_q) begin
            st_q       <= add_round_key(bus.plaintext, bus.key);
            rk_q       <= bus.key;
            rnd_q      <= 4'd1;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            state_q    <= RUN;
          end
        end
        RUN: begin
          st_q <= stage_st;
          rk_q <= stage_rk;
          if (final_pass) begin
            // rnd stays put so the counter never passes NR.
            ct_q        <= stage_st;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end else begin
            rnd_q <= rnd_q + 4'(UNROLL);
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            rnd_q       <= '0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.in_ready   = in_ready_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.ciphertext = ct_q;
  assign bus.busy       = busy_q;

endmodule

// File: tb/tb_aes128_iter_core.sv
// -----------------------------------------------------------------------------
// tb_aes128_iter_core
// Self-checking bench: four cores (UNROLL = 1, 2, 5, 10) on one clock/reset.
// Known-answer vectors, random blocks against a byte-level AES model,
// backpressure, mid-run reset, ignored input while busy, back-to-back.
// -----------------------------------------------------------------------------
module tb_aes128_iter_core;

  localparam int NDUT = 4;

  function automatic int unroll_of(input int d);
    case (d)
      0:       return 1;
      1:       return 2;
      2:       return 5;
      default: return 10;
    endcase
  endfunction

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic         in_valid  [NDUT];
  logic [127:0] pt_in     [NDUT];
  logic [127:0] key_in    [NDUT];
  logic         out_ready [NDUT];
  logic         in_ready  [NDUT];
  logic         out_valid [NDUT];
  logic [127:0] ct        [NDUT];
  logic         busy      [NDUT];

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    localparam int U = (g == 0) ? 1 : (g == 1) ? 2 : (g == 2) ? 5 : 10;
    aes128_iter_core_if bus ();
    assign bus.in_valid  = in_valid[g];
    assign bus.plaintext = pt_in[g];
    assign bus.key       = key_in[g];
    assign bus.out_ready = out_ready[g];
    assign in_ready[g]   = bus.in_ready;
    assign out_valid[g]  = bus.out_valid;
    assign ct[g]         = bus.ciphertext;
    assign busy[g]       = bus.busy;

    aes128_iter_core #(.UNROLL(U)) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
    );
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0] sbox_t [256];

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  // S-box from its definition: multiplicative inverse (x^254) then affine map.
  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h01;
      for (int k = 0; k < 254; k++) inv = gmul(inv, 8'(x));
      sbox_t[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [127:0] ref_aes(input logic [127:0] pt, input logic [127:0] key);
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [31:0]  w [44];
    logic [31:0]  tmp;
    logic [7:0]   rc;
    logic [127:0] res;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {tmp[23:0], tmp[31:24]};
        tmp = {sbox_t[tmp[31:24]], sbox_t[tmp[23:16]], sbox_t[tmp[15:8]], sbox_t[tmp[7:0]]} ^ {rc, 24'h0};
        rc  = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int b = 0; b < 16; b++) s[b] = pt[127-8*b -: 8] ^ key[127-8*b -: 8];
    for (int r = 1; r <= 10; r++) begin
      for (int b = 0; b < 16; b++) s[b] = sbox_t[s[b]];
      for (int c = 0; c < 4; c++)
        for (int row = 0; row < 4; row++) t[row+4*c] = s[row+4*((c+row)%4)];
      for (int c = 0; c < 4; c++)
        for (int row = 0; row < 4; row++)
          s[row+4*c] = (r < 10) ? gmul(8'h02, t[row+4*c]) ^ gmul(8'h03, t[(row+1)%4+4*c])
                                  ^ t[(row+2)%4+4*c] ^ t[(row+3)%4+4*c]
                                : t[row+4*c];
      for (int c = 0; c < 4; c++)
        for (int row = 0; row < 4; row++) s[row+4*c] = s[row+4*c] ^ w[4*r+c][31-8*row -: 8];
    end
    for (int b = 0; b < 16; b++) res[127-8*b -: 8] = s[b];
    return res;
  endfunction

  // ---------------- vectors ----------------
  typedef struct packed {
    logic [127:0] pt;
    logic [127:0] key;
    logic [127:0] ct;
  } vec_t;

  vec_t vecs [3];

  // ---------------- driver tasks ----------------
  task automatic wait_ready(input int d);
    int n = 0;
    while (!in_ready[d] && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check($sformatf("in_ready wait dut%0d", d), 128'(in_ready[d]), 128'd1);
  endtask

  task automatic send(input int d, input logic [127:0] pt, input logic [127:0] key);
    wait_ready(d);
    in_valid[d] = 1'b1;
    pt_in[d]    = pt;
    key_in[d]   = key;
    @(posedge clk); #1;
    in_valid[d] = 1'b0;
  endtask

  task automatic wait_out(input int d, output int lat);
    lat = 0;
    while (!out_valid[d] && lat < 64) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic release_out(input int d, input string name);
    out_ready[d] = 1'b1;
    @(posedge clk); #1;
    out_ready[d] = 1'b0;
    check({name, " out_valid drop"}, 128'(out_valid[d]), 128'd0);
    check({name, " in_ready back"}, 128'(in_ready[d]), 128'd1);
  endtask

  task automatic run_check(input int d, input string name, input logic [127:0] pt,
                           input logic [127:0] key, input logic [127:0] exp, input int hold);
    int lat;
    logic [127:0] scrap;
    send(d, pt, key);
    pt_in[d]  = ~pt;   // later input changes must not matter
    key_in[d] = ~key;
    wait_out(d, lat);
    check({name, " latency"}, 128'(lat), 128'(10 / unroll_of(d)));
    check({name, " ct"}, ct[d], exp);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      scrap = ct[d];
      check({name, " held ct"}, scrap, exp);
      check({name, " held valid"}, 128'(out_valid[d]), 128'd1);
    end
    release_out(d, name);
  endtask

  task automatic back_to_back(input int d);
    int cyc, acc_n, out_n, lat;
    int acc_t [2];
    int out_t [2];
    logic [127:0] got [2];
    logic acc;
    string nm;
    nm = $sformatf("b2b dut%0d", d);
    lat = 10 / unroll_of(d);
    cyc = 0; acc_n = 0; out_n = 0;
    acc_t = '{0, 0}; out_t = '{0, 0}; got = '{128'h0, 128'h0};
    out_ready[d] = 1'b1;
    in_valid[d]  = 1'b1;
    pt_in[d]     = vecs[0].pt;
    key_in[d]    = vecs[0].key;
    while (out_n < 2 && cyc < 200) begin
      acc = in_valid[d] && in_ready[d];
      @(posedge clk); #1;
      cyc++;
      if (acc && acc_n < 2) begin
        acc_t[acc_n] = cyc;
        acc_n++;
        if (acc_n == 1) begin
          pt_in[d]  = vecs[1].pt;
          key_in[d] = vecs[1].key;
        end else begin
          in_valid[d] = 1'b0;
        end
      end
      if (out_valid[d]) begin
        out_t[out_n] = cyc;
        got[out_n]   = ct[d];
        out_n++;
      end
    end
    in_valid[d] = 1'b0;
    @(posedge clk); #1;
    out_ready[d] = 1'b0;
    check({nm, " outputs"}, 128'(out_n), 128'd2);
    check({nm, " first ct"}, got[0], vecs[0].ct);
    check({nm, " second ct"}, got[1], vecs[1].ct);
    check({nm, " latency"}, 128'(out_t[0] - acc_t[0]), 128'(lat));
    check({nm, " accept spacing"}, 128'(acc_t[1] - acc_t[0]), 128'(lat + 2));
    check({nm, " output spacing"}, 128'(out_t[1] - out_t[0]), 128'(lat + 2));
    check({nm, " idle after"}, 128'(in_ready[d]), 128'd1);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int           lat, seen;
    logic [127:0] rpt, rkey;

    vecs[0] = '{pt:  128'h3243f6a8885a308d313198a2e0370734,
                key: 128'h2b7e151628aed2a6abf7158809cf4f3c,
                ct:  128'h3925841d02dc09fbdc118597196a0b32};
    vecs[1] = '{pt:  128'h00112233445566778899aabbccddeeff,
                key: 128'h000102030405060708090a0b0c0d0e0f,
                ct:  128'h69c4e0d86a7b0430d8cdb78070b4c55a};
    vecs[2] = '{pt:  128'h0,
                key: 128'h0,
                ct:  128'h66e94bd4ef8a2c3b884cfa59ca342b2e};

    build_sbox();
    for (int d = 0; d < NDUT; d++) begin
      in_valid[d] = 1'b0; out_ready[d] = 1'b0;
      pt_in[d] = '0; key_in[d] = '0;
    end

    // Reset state
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < NDUT; d++) begin
      check($sformatf("reset out_valid dut%0d", d), 128'(out_valid[d]), 128'd0);
      check($sformatf("reset busy dut%0d", d), 128'(busy[d]), 128'd0);
      check($sformatf("reset ct dut%0d", d), ct[d], 128'd0);
      check($sformatf("reset in_ready dut%0d", d), 128'(in_ready[d]), 128'd0);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    for (int d = 0; d < NDUT; d++)
      check($sformatf("post-reset in_ready dut%0d", d), 128'(in_ready[d]), 128'd1);

    // Known-answer table on every UNROLL
    for (int d = 0; d < NDUT; d++)
      for (int v = 0; v < 3; v++)
        run_check(d, $sformatf("kat%0d dut%0d", v, d), vecs[v].pt, vecs[v].key, vecs[v].ct, 0);

    // Random blocks against the model, with random backpressure
    for (int d = 0; d < NDUT; d++)
      for (int n = 0; n < 4; n++) begin
        rpt  = {$urandom, $urandom, $urandom, $urandom};
        rkey = {$urandom, $urandom, $urandom, $urandom};
        run_check(d, $sformatf("rand%0d dut%0d", n, d), rpt, rkey, ref_aes(rpt, rkey),
                  int'($urandom_range(0, 3)));
      end

    // Backpressure held for 20 cycles (UNROLL=1)
    send(0, vecs[0].pt, vecs[0].key);
    wait_out(0, lat);
    check("bp latency", 128'(lat), 128'd10);
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      check("bp ct", ct[0], vecs[0].ct);
      check("bp out_valid", 128'(out_valid[0]), 128'd1);
      check("bp in_ready", 128'(in_ready[0]), 128'd0);
      check("bp busy", 128'(busy[0]), 128'd1);
    end
    release_out(0, "bp");
    check("bp busy clear", 128'(busy[0]), 128'd0);

    // Reset in the middle of a run
    send(0, vecs[1].pt, vecs[1].key);
    repeat (3) @(posedge clk);
    #1;
    check("midrst busy before", 128'(busy[0]), 128'd1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("midrst out_valid", 128'(out_valid[0]), 128'd0);
    check("midrst ct", ct[0], 128'd0);
    check("midrst busy", 128'(busy[0]), 128'd0);
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (out_valid[0]) seen++;
    end
    check("midrst no stale output", 128'(seen), 128'd0);
    run_check(0, "midrst rerun", vecs[1].pt, vecs[1].key, vecs[1].ct, 0);

    // Input ignored while busy
    send(0, vecs[0].pt, vecs[0].key);
    lat = 0; seen = 0;
    for (int i = 0; i < 13; i++) begin
      in_valid[0] = 1'b1;
      pt_in[0]    = {$urandom, $urandom, $urandom, $urandom};
      key_in[0]   = {$urandom, $urandom, $urandom, $urandom};
      @(posedge clk); #1;
      if (out_valid[0] && lat == 0) lat = i + 1;
    end
    in_valid[0] = 1'b0;
    check("busy-ignore latency", 128'(lat), 128'd10);
    check("busy-ignore ct", ct[0], vecs[0].ct);
    release_out(0, "busy-ignore");
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      if (out_valid[0] || busy[0]) seen++;
    end
    check("busy-ignore no second block", 128'(seen), 128'd0);

    // Back-to-back streaming on every UNROLL
    for (int d = 0; d < NDUT; d++) back_to_back(d);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Absolute guard against a hung run.
  initial begin
    #500000;
    $display("FAIL global timeout: got running want finished");
    $fatal(1, "timeout");
  end

endmodule
